// File: rtl/mmio_arbiter_if.sv
// mmio_arbiter_if: one master's request/response channel into mmio_arbiter.
// The master modport belongs to the requesting agent (CPU data path or
// debug/loader). The slave modport belongs to the arbiter.
interface mmio_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              req;
  logic [3:0]        we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              lock;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, din, lock,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, din, lock,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: shares the single MMIO port (UART, counters) between
// master 0 (CPU data path) and master 1 (debug/loader).
//   edge N   : grant (combinational gnt, round-robin on conflict)
//   cycle N+1: registered single-cycle MMIO access
//   cycle N+2: registered rvalid pulse and rdata to the owning master
// Exactly one MMIO strobe is issued per grant, so read side effects such as
// popping the UART receive FIFO happen exactly once.
// Optional feature macro: MMIO_ARB_LOCK_EN (sticky grant for atomic pairs).
module mmio_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  mmio_arbiter_if.slave     m0,
  mmio_arbiter_if.slave     m1,
  output logic              mmio_en,
  output logic [3:0]        mmio_we,
  output logic [ADDR_W-1:0] mmio_addr,
  output logic [DATA_W-1:0] mmio_din,
  input  logic [DATA_W-1:0] mmio_dout
);

  logic              last;      // index of the most recently granted master
  logic              owner;     // master that owns the access in flight
  logic              is_read;   // access in flight is a read (we == 0)
  logic              gnt0;
  logic              gnt1;
  logic              hold0;     // lock forces the grant to master 0
  logic              hold1;     // lock forces the grant to master 1
  logic [3:0]        sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_din;

`ifdef MMIO_ARB_LOCK_EN
  logic lock_active;
  logic lock_owner;

  // A held lock only forces its owner while that owner is still requesting.
  // A dropped request ends the lock in the same cycle.
  always_comb begin
    hold0 = lock_active & ~lock_owner & m0.req;
    hold1 = lock_active &  lock_owner & m1.req;
  end

  // Track the lock: set or cleared on each grant, dropped when its owner withdraws.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_active <= 1'b0;
      lock_owner  <= 1'b0;
    end else if (gnt0) begin
      lock_active <= m0.lock;
      lock_owner  <= 1'b0;
    end else if (gnt1) begin
      lock_active <= m1.lock;
      lock_owner  <= 1'b1;
    end else if (lock_active && !(lock_owner ? m1.req : m0.req)) begin
      lock_active <= 1'b0;
    end else begin
      lock_active <= lock_active;
    end
  end
`else
  logic unused_lock;

  assign unused_lock = m0.lock ^ m1.lock;

  // Without the lock feature, arbitration is pure round-robin.
  always_comb begin
    hold0 = 1'b0;
    hold1 = 1'b0;
  end
`endif

  // Grant decision: lock first, then round-robin on conflict. Grants are held off during reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end else if (hold0) begin
      gnt0 = 1'b1;
    end else if (hold1) begin
      gnt1 = 1'b1;
    end else if (m0.req && m1.req) begin
      if (last) begin
        gnt0 = 1'b1;
      end else begin
        gnt1 = 1'b1;
      end
    end else if (m0.req) begin
      gnt0 = 1'b1;
    end else if (m1.req) begin
      gnt1 = 1'b1;
    end else begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign m0.gnt = gnt0;
  assign m1.gnt = gnt1;

  // Select the winning master's access fields.
  always_comb begin
    if (gnt1) begin
      sel_we   = m1.we;
      sel_addr = m1.addr;
      sel_din  = m1.din;
    end else begin
      sel_we   = m0.we;
      sel_addr = m0.addr;
      sel_din  = m0.din;
    end
  end

  // Access stage: load the winner on a grant, and strobe mmio_en for exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mmio_en   <= 1'b0;
      mmio_we   <= 4'b0000;
      mmio_addr <= {ADDR_W{1'b0}};
      mmio_din  <= {DATA_W{1'b0}};
      owner     <= 1'b0;
      is_read   <= 1'b0;
      last      <= 1'b1;
    end else if (gnt0 || gnt1) begin
      mmio_en   <= 1'b1;
      mmio_we   <= sel_we;
      mmio_addr <= sel_addr;
      mmio_din  <= sel_din;
      owner     <= gnt1;
      is_read   <= (sel_we == 4'b0000);
      last      <= gnt1;
    end else begin
      mmio_en   <= 1'b0;
    end
  end

  // Response stage: pulse rvalid to the owner. Reads return mmio_dout and writes return 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= {DATA_W{1'b0}};
      m1.rdata  <= {DATA_W{1'b0}};
    end else begin
      m0.rvalid <= mmio_en & ~owner;
      m1.rvalid <= mmio_en &  owner;
      if (mmio_en && !owner) begin
        m0.rdata <= is_read ? mmio_dout : {DATA_W{1'b0}};
      end else begin
        m0.rdata <= m0.rdata;
      end
      if (mmio_en && owner) begin
        m1.rdata <= is_read ? mmio_dout : {DATA_W{1'b0}};
      end else begin
        m1.rdata <= m1.rdata;
      end
    end
  end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: scoreboard bench for mmio_arbiter.
// Grants push expected MMIO accesses. Observed accesses push expected responses.
// Both queues are checked every cycle on the falling edge.
module tb_mmio_arbiter;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              mmio_en;
  logic [3:0]        mmio_we;
  logic [ADDR_W-1:0] mmio_addr;
  logic [DATA_W-1:0] mmio_din;
  logic [DATA_W-1:0] mmio_dout;
  logic              use_fixed;
  logic [DATA_W-1:0] dout_val;

  mmio_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m0_if ();
  mmio_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) m1_if ();

  mmio_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0_if),
    .m1        (m1_if),
    .mmio_en   (mmio_en),
    .mmio_we   (mmio_we),
    .mmio_addr (mmio_addr),
    .mmio_din  (mmio_din),
    .mmio_dout (mmio_dout)
  );

  always #5 clk = ~clk;

  // MMIO device model: either a value set by the test or an address-derived pattern.
  always_comb mmio_dout = use_fixed ? dout_val : {16'hD000, 2'b00, mmio_addr};

  typedef struct {
    int                cyc;
    logic              m;
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
  } acc_t;

  typedef struct {
    int                cyc;
    logic [DATA_W-1:0] data;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp0_q[$];
  rsp_t rsp1_q[$];
  int   grant_log[$];
  logic [DATA_W-1:0] rd0_log[$];
  int   rd0_cyc[$];

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    acc_t a;
    rsp_t r;
    bit   exp_en;
    bit   exp_v0;
    bit   exp_v1;
    if (!reset) begin
      exp_v0 = (rsp0_q.size() > 0) && (rsp0_q[0].cyc == cycle);
      check("m0_rvalid", {31'd0, m0_if.rvalid}, {31'd0, exp_v0});
      if (exp_v0) begin
        r = rsp0_q.pop_front();
        check("m0_rdata", m0_if.rdata, r.data);
      end
      if (m0_if.rvalid) begin
        rd0_log.push_back(m0_if.rdata);
        rd0_cyc.push_back(cycle);
      end
      exp_v1 = (rsp1_q.size() > 0) && (rsp1_q[0].cyc == cycle);
      check("m1_rvalid", {31'd0, m1_if.rvalid}, {31'd0, exp_v1});
      if (exp_v1) begin
        r = rsp1_q.pop_front();
        check("m1_rdata", m1_if.rdata, r.data);
      end

      exp_en = (acc_q.size() > 0) && (acc_q[0].cyc == cycle);
      check("mmio_en", {31'd0, mmio_en}, {31'd0, exp_en});
      if (exp_en) begin
        a = acc_q.pop_front();
        check("mmio_we", {28'd0, mmio_we}, {28'd0, a.we});
        check("mmio_addr", {18'd0, mmio_addr}, {18'd0, a.addr});
        check("mmio_din", mmio_din, a.din);
        r.cyc  = cycle + 1;
        r.data = (a.we == 4'b0000) ? mmio_dout : 32'h0000_0000;
        if (a.m) rsp1_q.push_back(r);
        else     rsp0_q.push_back(r);
      end

      check("gnt_onehot", {31'd0, m0_if.gnt & m1_if.gnt}, 32'd0);
      check("gnt0_needs_req", {31'd0, m0_if.gnt & ~m0_if.req}, 32'd0);
      check("gnt1_needs_req", {31'd0, m1_if.gnt & ~m1_if.req}, 32'd0);
      if (m0_if.gnt || m1_if.gnt) begin
        a.cyc  = cycle + 1;
        a.m    = m1_if.gnt;
        a.we   = m1_if.gnt ? m1_if.we   : m0_if.we;
        a.addr = m1_if.gnt ? m1_if.addr : m0_if.addr;
        a.din  = m1_if.gnt ? m1_if.din  : m0_if.din;
        acc_q.push_back(a);
        grant_log.push_back(m1_if.gnt ? 1 : 0);
      end
    end
  end

  // Drive one request and hold it until granted. Returns at the start of the access cycle.
  task automatic issue(input int m, input logic [3:0] we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] din, input logic lock, output int waited);
    bit got;
    got    = 1'b0;
    waited = 0;
    if (m == 0) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = addr; m0_if.din = din; m0_if.lock = lock;
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = addr; m1_if.din = din; m1_if.lock = lock;
    end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = (m == 0) ? m0_if.gnt : m1_if.gnt;
      waited++;
      @(posedge clk);
      #1;
    end
    check("gnt_wait", {31'd0, got}, 32'd1);
    if (m == 0) m0_if.req = 1'b0;
    else        m1_if.req = 1'b0;
  endtask

  task automatic flush_model();
    acc_q.delete();
    rsp0_q.delete();
    rsp1_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1;
    use_fixed = 1'b1;
    dout_val = 32'h0000_1234;
    m0_if.req = 1'b1; m0_if.we = 4'b0000; m0_if.addr = '0; m0_if.din = '0; m0_if.lock = 1'b0;
    m1_if.req = 1'b1; m1_if.we = 4'b0000; m1_if.addr = '0; m1_if.din = '0; m1_if.lock = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state. Requests are held high to show that grants stay off.
    check("rst_gnt0", {31'd0, m0_if.gnt}, 32'd0);
    check("rst_gnt1", {31'd0, m1_if.gnt}, 32'd0);
    check("rst_mmio_en", {31'd0, mmio_en}, 32'd0);
    check("rst_mmio_we", {28'd0, mmio_we}, 32'd0);
    check("rst_mmio_addr", {18'd0, mmio_addr}, 32'd0);
    check("rst_mmio_din", mmio_din, 32'd0);
    check("rst_rvalid", {30'd0, m0_if.rvalid, m1_if.rvalid}, 32'd0);
    check("rst_rdata0", m0_if.rdata, 32'd0);
    check("rst_rdata1", m1_if.rdata, 32'd0);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single read by m0: grant in cycle 0, strobe in cycle 1, response in cycle 2.
    issue(0, 4'b0000, 14'h0010, 32'h0, 1'b0, w);
    check("t1_gnt_latency", w, 32'd1);
    check("t1_en", {31'd0, mmio_en}, 32'd1);
    check("t1_addr", {18'd0, mmio_addr}, 32'h10);
    @(posedge clk); #1;
    check("t1_rvalid", {31'd0, m0_if.rvalid}, 32'd1);
    check("t1_rdata", m0_if.rdata, 32'h0000_1234);
    check("t1_en_drop", {31'd0, mmio_en}, 32'd0);
    @(posedge clk); #1;
    check("t1_rvalid_pulse", {31'd0, m0_if.rvalid}, 32'd0);

    // Byte write by m1.
    issue(1, 4'b0001, 14'h0008, 32'h0000_0041, 1'b0, w);
    check("t2_we", {28'd0, mmio_we}, 32'd1);
    check("t2_din", mmio_din, 32'h41);
    @(posedge clk); #1;
    check("t2_en_one_cycle", {31'd0, mmio_en}, 32'd0);
    check("t2_m1_rvalid", {31'd0, m1_if.rvalid}, 32'd1);
    check("t2_m1_rdata", m1_if.rdata, 32'd0);
    check("t2_m0_rdata_held", m0_if.rdata, 32'h0000_1234);
    repeat (2) @(posedge clk); #1;

    // Conflict over 4 read beats: grants alternate starting with m0.
    use_fixed = 1'b0;
    grant_log.delete();
    fork
      begin issue(0, 4'b0000, 14'h0100, 32'h0, 1'b0, w); issue(0, 4'b0000, 14'h0104, 32'h0, 1'b0, w); end
      begin issue(1, 4'b0000, 14'h0200, 32'h0, 1'b0, w); issue(1, 4'b0000, 14'h0204, 32'h0, 1'b0, w); end
    join
    repeat (3) @(posedge clk); #1;
    check("t3_grants", grant_log.size(), 32'd4);
    if (grant_log.size() == 4) begin
      check("t3_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
            32'h00_01_00_01);
    end

    // Back-to-back m0 reads of 0x04 with changing device data.
    use_fixed = 1'b1;
    rd0_log.delete();
    rd0_cyc.delete();
    issue(0, 4'b0000, 14'h0004, 32'h0, 1'b0, w);
    dout_val = 32'h0000_00A5;
    issue(0, 4'b0000, 14'h0004, 32'h0, 1'b0, w);
    check("t4_en_second", {31'd0, mmio_en}, 32'd1);
    dout_val = 32'h0000_005A;
    repeat (3) @(posedge clk); #1;
    check("t4_resp_count", rd0_log.size(), 32'd2);
    if (rd0_log.size() == 2) begin
      check("t4_rdata_first", rd0_log[0], 32'hA5);
      check("t4_rdata_second", rd0_log[1], 32'h5A);
      check("t4_consecutive", rd0_cyc[1] - rd0_cyc[0], 32'd1);
    end

    // Reset while an access is on the MMIO port.
    issue(0, 4'b0000, 14'h0010, 32'h0, 1'b0, w);
    check("t5_en_before", {31'd0, mmio_en}, 32'd1);
    reset = 1'b1;
    flush_model();
    #1;
    check("t5_en_async", {31'd0, mmio_en}, 32'd0);
    m1_if.req = 1'b1;
    @(posedge clk); #1;
    check("t5_gnt_held", {31'd0, m1_if.gnt}, 32'd0);
    check("t5_no_rvalid", {31'd0, m0_if.rvalid}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    m1_if.req = 1'b0;
    grant_log.delete();
    fork
      issue(0, 4'b0000, 14'h0010, 32'h0, 1'b0, w);
      issue(1, 4'b0000, 14'h0014, 32'h0, 1'b0, w);
    join
    check("t5_first_winner", grant_log.size() > 0 ? grant_log[0] : 99, 32'd0);
    repeat (3) @(posedge clk); #1;

    // Lock: m0 runs 3 beats with lock 1,1,0 while m1 requests continuously.
    apply_reset();
    grant_log.delete();
    fork
      begin
        issue(0, 4'b0000, 14'h0000, 32'h0, 1'b1, w);
        issue(0, 4'b0000, 14'h0004, 32'h0, 1'b1, w);
        issue(0, 4'b0000, 14'h0004, 32'h0, 1'b0, w);
      end
      begin
        issue(1, 4'b0000, 14'h0030, 32'h0, 1'b0, w);
        issue(1, 4'b0000, 14'h0034, 32'h0, 1'b0, w);
      end
    join
    repeat (3) @(posedge clk); #1;
    check("t6_grants", grant_log.size(), 32'd5);
    if (grant_log.size() >= 4) begin
`ifdef MMIO_ARB_LOCK_EN
      check("t6_lock_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
            32'h00_00_00_01);
`else
      check("t6_rr_order", {grant_log[0][7:0], grant_log[1][7:0], grant_log[2][7:0], grant_log[3][7:0]},
            32'h00_01_00_01);
`endif
    end

    repeat (3) @(posedge clk); #1;
    check("drain_acc", acc_q.size(), 32'd0);
    check("drain_rsp0", rsp0_q.size(), 32'd0);
    check("drain_rsp1", rsp1_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-port arbiter that shares the single memory-mapped I/O port (UART control/data, cycle/instruction counters) between the CPU data path (master 0) and a debug/loader master (master 1). It accepts requests with a req/gnt handshake and applies round-robin arbitration on conflict. It issues exactly one registered single-cycle access to the MMIO port per grant and returns read data with a one-cycle valid pulse. Read side effects, such as popping the UART receive FIFO, therefore occur exactly once per granted read.

## Interface
- `ADDR_W`, 14, MMIO address width
- `DATA_W`, 32, data width

- `clk` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `m0_req`, `m1_req` in 1: access request; held until `mN_gnt`
- `m0_we`, `m1_we` in 4: byte write enables; 0 means read
- `m0_addr`, `m1_addr` in `ADDR_W`: access address
- `m0_din`, `m1_din` in `DATA_W`: write data
- `m0_lock`, `m1_lock` in 1: keep the grant on the next beat (see Configuration)
- `m0_gnt`, `m1_gnt` out 1: combinational; request accepted at this edge
- `m0_rvalid`, `m1_rvalid` out 1: response pulse, 1 cycle
- `m0_rdata`, `m1_rdata` out `DATA_W`: response data, valid with `rvalid`
- `mmio_en` out 1: registered access strobe
- `mmio_we` out 4: registered
- `mmio_addr` out `ADDR_W`: registered
- `mmio_din` out `DATA_W`: registered
- `mmio_dout` in `DATA_W`: combinational read data from the MMIO port

## Operation
- Arbitration is evaluated every cycle from `m0_req`, `m1_req`, the `last` pointer, and the lock state.
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master not equal to `last`.
  - `last` updates to the granted index on every grant.
- At most one `gnt` is high per cycle. `gnt` is high only when the corresponding `req` is high.
- On a grant at edge N:
  - `mmio_en`, `mmio_we`, `mmio_addr`, and `mmio_din` are loaded from the winner and driven during cycle N+1.
  - `mmio_en` drops in N+2 unless a new grant occurred at edge N+1.
- The access stage holds `owner` (the granted index) and `is_read` (`mmio_we==0`).
  - At edge N+1→N+2, `mmio_dout` is captured into `owner`'s `rdata` if `is_read`; otherwise `rdata` is 0.
  - `owner`'s `rvalid` pulses during N+2.
- The pipeline sustains one access per cycle, with back-to-back grants allowed.
- `rdata` holds its value until the next response to the same master.
- There are no errors or timeouts. An unmapped address is passed through unchanged.

## Timing
- Grant: same cycle as `req`, when won.
- MMIO strobe: 1 cycle after grant.
- Response: 2 cycles after grant.
- Reset values:
  - `gnt` 0 (held 0 during reset).
  - `mmio_en`/`mmio_we`/`mmio_addr`/`mmio_din` all 0.
  - `rvalid` 0, `rdata` 0.
  - `last` = 1, so master 0 wins the first conflict.
  - `lock` state cleared.
- Reset mid-operation: an in-flight access or response is discarded. No `rvalid` is issued for it, and `mmio_en` goes 0 immediately (asynchronous).
- Simultaneous request with a pending response: independent. A master may receive `rvalid` for beat k and `gnt` for beat k+1 in the same cycle.
- `req` deasserted without a grant: legal, the request is withdrawn, and `last` is unchanged.

## Configuration
- Macro: `MMIO_ARB_LOCK_EN`.
- Defined: after a grant to master X with `mX_lock=1`, the arbiter grants only master X while `mX_lock` stays high at grant time. The other master's `gnt` is held 0 even under conflict. Lock ends on the first grant to X with `mX_lock=0`, or on the first cycle X's `req` is low; arbitration then resumes round-robin. This guarantees atomic status-poll/read pairs (`UART_CONTROL` then `UART_RECEIVE_DATA`).
- Not defined: the `lock` inputs are ignored (ports remain) and arbitration is pure round-robin.

## Test plan
- After reset, m0 reads 0x10 alone, with `mmio_dout`=0x0000_1234 → `m0_gnt` at cycle 0, `mmio_en`=1 and `mmio_addr`=0x10 at cycle 1, `m0_rvalid`=1 and `m0_rdata`=0x1234 at cycle 2.
- Both request continuously for 4 beats (reads) → grant order m0, m1, m0, m1; exactly one `mmio_en` cycle per grant; responses route to the matching master.
- m1 writes `we`=4'b0001, addr 0x08, `din`=0x41 → `mmio_we`=1, `mmio_din`=0x41 for one cycle; `m1_rvalid` pulses with `rdata`=0.
- Back-to-back m0 reads of 0x04 with `mmio_dout` 0xA5 then 0x5A → `mmio_en` high for 2 consecutive cycles; `m0_rdata` 0xA5 then 0x5A on consecutive `rvalid` cycles.
- Assert `reset` in the cycle `mmio_en`=1 → `mmio_en` goes 0 immediately; no `rvalid` follows; the next conflict is won by m0.
- With `MMIO_ARB_LOCK_EN`, m0 issues 3 beats with `lock` 1,1,0 while m1 requests continuously → grants m0, m0, m0, then m1. Without the macro → m0, m1, m0, m1.
